pic_buf_ctrl: RTL and testbench
===============================

# pic_buf_ctrl

Ping-pong frame-buffer controller for the 98x98 Sobel result picture shown on the VGA output. It takes the received pixel byte stream and writes it into one half of a two-bank picture RAM while the VGA read side scans the other half. It swaps banks only at a VGA frame boundary, and only after a complete picture has been written. It supplies write and read addresses to the dual-port RAM, an "image valid" flag for display muxing, and a drop indicator for bytes lost while waiting for a swap.

## Interface
- PIC_W, 98, picture width in pixels
- PIC_H, 98, picture height in pixels
- PIX_NUM, PIC_W*PIC_H (9604), pixels per bank
- AW, 14, per-bank address width; must satisfy 2**AW >= PIX_NUM
- IDLE_TO, 2_500_000, sys_clk cycles without a byte before a partial picture is discarded

Ports:
- sys_clk  in  1  system/VGA clock; single clock domain
- sys_rst  in  1  synchronous, active-high reset
- pi_data  in  8  received pixel byte
- pi_flag  in  1  one-cycle strobe; pi_data is valid
- rd_en  in  1  VGA read-side pixel request; high while the scan is inside the picture window
- frame_end  in  1  one-cycle pulse on the last pixel of each VGA frame
- wr_en  out  1  RAM write enable
- wr_addr  out  AW+1  RAM write address, {wr_bank, wcnt}
- wr_data  out  8  RAM write data
- rd_addr  out  AW+1  RAM read address, {rd_bank, rcnt}
- img_valid  out  1  at least one complete picture has been swapped in for display
- ovf  out  1  one-cycle pulse for each dropped byte

## Operation
- State registers: wr_bank, rd_bank, wcnt (AW bits), rcnt (AW bits), idle counter (enough bits for IDLE_TO), write FSM state {FILL, DONE}.
- Reset values: state=FILL, wr_bank=0, rd_bank=1, wcnt=0, rcnt=0, idle=0.
- Output reset values: wr_en=0, wr_addr=0, wr_data=0, rd_addr=2**AW (bank 1, offset 0), img_valid=0, ovf=0.
- A reset in the middle of a fill discards the partial picture. img_valid returns to 0.

FILL:
- On pi_flag: wr_en=1, wr_addr={wr_bank,wcnt}, wr_data=pi_data, then wcnt++ and idle=0.
- If pi_flag arrives with wcnt==PIX_NUM-1: the byte is written, wcnt→0, state→DONE.
- Without pi_flag and with wcnt!=0: idle++. When idle reaches IDLE_TO-1, wcnt→0 and idle→0 (resync to the start of a picture). No other outputs change.
- With wcnt==0: idle is held at 0.

DONE:
- A pi_flag byte is dropped: wr_en stays 0 and ovf=1 for one cycle.
- On frame_end: rd_bank←wr_bank, wr_bank←~wr_bank, rcnt→0, img_valid→1, state→FILL.
- frame_end and pi_flag in the same cycle: the swap happens and the byte is accepted, not dropped. It is written to {new wr_bank, 0}, wcnt→1, ovf=0.

Read side, every state:
- rd_en=1: rcnt increments. It wraps to 0 after PIX_NUM-1.
- frame_end: rcnt→0. This has priority over a simultaneous rd_en.
- frame_end in FILL: rcnt→0 only; no swap.

Width rules:
- wcnt and rcnt never exceed PIX_NUM-1.
- Bank bit is the MSB of each address.

## Timing
- All outputs are registered.
- wr_en, wr_addr and wr_data appear 1 cycle after the pi_flag cycle. wr_en is high for exactly 1 cycle per accepted byte.
- rd_addr updates 1 cycle after the rd_en or frame_end cycle. The RAM read latency is not part of this block.
- A bank swap is visible on rd_addr and img_valid the cycle after frame_end.
- ovf is high the cycle after the dropped pi_flag.
- The idle resync takes effect the cycle after the IDLE_TO-th consecutive idle cycle of a partial fill.
- Back-to-back pi_flag is supported, one byte per cycle.

## Test plan
All scenarios use PIC_W=4, PIC_H=2 (PIX_NUM=8), AW=3, IDLE_TO=16, so rd_addr reset value is 8.
- Reset: assert sys_rst for 3 cycles while pi_flag toggles → wr_en=0, wr_addr=0, rd_addr=8, img_valid=0, ovf=0 throughout. No write occurs.
- Full fill and swap: send 8 bytes 0x10..0x17 back-to-back → wr_addr 0..7, wr_data 0x10..0x17, state DONE. Then pulse frame_end → next cycle rd_addr=0, img_valid=1. The next byte 0x20 writes to wr_addr=8.
- Overflow: after a full fill and before frame_end, send 3 bytes → 3 ovf pulses, no wr_en. After frame_end, byte 0x30 writes to wr_addr=8.
- Simultaneous events: in DONE, assert pi_flag (0x55) together with frame_end → swap occurs, wr_addr=8, wr_data=0x55, ovf=0. The following byte writes to address 9.
- Idle resync: send 3 bytes to addresses 0..2, wait 16 idle cycles, send 0x77 → written at wr_addr=0, not 3.
- Read scan: hold rd_en for 10 cycles → rd_addr sequence base+0..7, base+0, base+1. Pulse frame_end with rd_en at rcnt=5 → rcnt=0 next cycle. Reset asserted mid-fill at wcnt=4 → next byte after reset lands at wr_addr=0.

Source files
------------

// File: rtl/pic_buf_ctrl.sv
// rtl/pic_buf_ctrl.sv - ping-pong picture buffer controller for the VGA Sobel result frame
module pic_buf_ctrl #(
  parameter int PIC_W   = 98,
  parameter int PIC_H   = 98,
  parameter int PIX_NUM = PIC_W * PIC_H,
  parameter int AW      = 14,
  parameter int IDLE_TO = 2_500_000
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [7:0]    pi_data,
  input  logic          pi_flag,
  input  logic          rd_en,
  input  logic          frame_end,
  output logic          wr_en,
  output logic [AW:0]   wr_addr,
  output logic [7:0]    wr_data,
  output logic [AW:0]   rd_addr,
  output logic          img_valid,
  output logic          ovf
);

  localparam int IW = $clog2(IDLE_TO + 1);
  localparam logic [AW-1:0] LAST      = AW'(PIX_NUM - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TO - 1);

  typedef enum logic {FILL, DONE} state_e;

  state_e        state_q, state_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          wr_en_q, wr_en_d;
  logic [AW:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          img_valid_q, img_valid_d;
  logic          ovf_q, ovf_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= FILL;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      idle_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      img_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      idle_q      <= idle_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      img_valid_q <= img_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    idle_d      = idle_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    img_valid_d = img_valid_q;
    ovf_d       = 1'b0;

    // Read scan; frame_end restarts it and wins over rd_en.
    if (rd_en) begin
      rcnt_d = (rcnt_q == LAST) ? '0 : rcnt_q + AW'(1);
    end
    if (frame_end) begin
      rcnt_d = '0;
    end

    case (state_q)
      FILL: begin
        if (pi_flag) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {wr_bank_q, wcnt_q};
          wr_data_d = pi_data;
          idle_d    = '0;
          if (wcnt_q == LAST) begin
            wcnt_d  = '0;
            state_d = DONE;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end else if (wcnt_q != '0) begin
          // A stalled partial picture is abandoned so the next byte starts a fresh one.
          if (idle_q == IDLE_LAST) begin
            wcnt_d = '0;
            idle_d = '0;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end else begin
          idle_d = '0;
        end
      end
      DONE: begin
        idle_d = '0;
        if (frame_end) begin
          rd_bank_d   = wr_bank_q;
          wr_bank_d   = ~wr_bank_q;
          img_valid_d = 1'b1;
          state_d     = FILL;
          if (pi_flag) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {~wr_bank_q, {AW{1'b0}}};
            wr_data_d = pi_data;
            wcnt_d    = (LAST == '0) ? '0 : AW'(1);
            state_d   = (LAST == '0) ? DONE : FILL;
          end
        end else if (pi_flag) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = {rd_bank_q, rcnt_q};
  assign img_valid = img_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pic_buf_ctrl.sv
// tb/tb_pic_buf_ctrl.sv - directed vector bench for pic_buf_ctrl on a 4x2 picture
module tb_pic_buf_ctrl;

  localparam int AW = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [7:0]    pi_data;
  logic          pi_flag;
  logic          rd_en;
  logic          frame_end;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [7:0]    wr_data;
  logic [AW:0]   rd_addr;
  logic          img_valid;
  logic          ovf;

  int checks   = 0;
  int failures = 0;

  pic_buf_ctrl #(
    .PIC_W(4), .PIC_H(2), .AW(AW), .IDLE_TO(16)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
    .rd_en(rd_en), .frame_end(frame_end), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .img_valid(img_valid), .ovf(ovf)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rst;
    logic       flag;
    logic [7:0] data;
    logic       fe;
    logic       e_wen;
    logic [3:0] e_waddr;
    logic [7:0] e_wdata;
    logic [3:0] e_raddr;
    logic       e_iv;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic flag, input logic [7:0] data,
                     input logic fe, input logic e_wen, input logic [3:0] e_waddr,
                     input logic [7:0] e_wdata, input logic [3:0] e_raddr,
                     input logic e_iv, input logic e_ovf);
    vec_t v;
    v.rst = rst; v.flag = flag; v.data = data; v.fe = fe;
    v.e_wen = e_wen; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_raddr = e_raddr; v.e_iv = e_iv; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic flag, input logic [7:0] data,
                      input logic rden, input logic fe);
    sys_rst = rst; pi_flag = flag; pi_data = data; rd_en = rden; frame_end = fe;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst = 1'b1; pi_flag = 1'b0; pi_data = 8'h00; rd_en = 1'b0; frame_end = 1'b0;

    // reset with pi_flag toggling
    add(1, 1, 8'hAA, 0, 0, 0, 8'h00, 4'd8, 0, 0);
    add(1, 0, 8'hAB, 0, 0, 0, 8'h00, 4'd8, 0, 0);
    add(1, 1, 8'hAC, 0, 0, 0, 8'h00, 4'd8, 0, 0);
    // full fill of bank 0
    for (int i = 0; i < 8; i++) add(0, 1, 8'h10 + 8'(i), 0, 1, 4'(i), 8'h10 + 8'(i), 4'd8, 0, 0);
    // three dropped bytes while waiting for the swap
    for (int i = 0; i < 3; i++) add(0, 1, 8'hE0 + 8'(i), 0, 0, 0, 8'h00, 4'd8, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 4'd8, 0, 0);
    // swap: display bank 0, write bank 1
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 4'd0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 8'h30 + 8'(i), 0, 1, 4'd8 + 4'(i), 8'h30 + 8'(i), 4'd0, 1, 0);
    // reset mid-fill at wcnt=4
    add(1, 1, 8'hEE, 0, 0, 0, 8'h00, 4'd8, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 8'h99 + 8'(i), 0, 1, 4'(i), 8'h99 + 8'(i), 4'd8, 0, 0);
    // frame_end with a byte in DONE: swap and accept
    add(0, 1, 8'h55, 1, 1, 4'd8, 8'h55, 4'd0, 1, 0);
    add(0, 1, 8'h56, 0, 1, 4'd9, 8'h56, 4'd0, 1, 0);
    add(0, 1, 8'h57, 0, 1, 4'd10, 8'h57, 4'd0, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].flag, vecs[i].data, 1'b0, vecs[i].fe);
      chk("wr_en", i, 16'(wr_en), 16'(vecs[i].e_wen));
      chk("ovf", i, 16'(ovf), 16'(vecs[i].e_ovf));
      chk("rd_addr", i, 16'(rd_addr), 16'(vecs[i].e_raddr));
      chk("img_valid", i, 16'(img_valid), 16'(vecs[i].e_iv));
      if (vecs[i].e_wen || vecs[i].rst) begin
        chk("wr_addr", i, 16'(wr_addr), 16'(vecs[i].e_waddr));
        chk("wr_data", i, 16'(wr_data), 16'(vecs[i].e_wdata));
      end
    end

    // 15 idle cycles: partial picture survives, next byte continues at 11
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 8'h00, 0, 0);
      chk("idle15_wr_en", i, 16'(wr_en), 16'd0);
    end
    step(0, 1, 8'h58, 0, 0);
    chk("idle15_wr_addr", 0, 16'(wr_addr), 16'd11);
    chk("idle15_wr_en", 15, 16'(wr_en), 16'd1);
    // 16 idle cycles: resync, next byte restarts at bank 1 offset 0
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 0, 0);
      chk("idle16_wr_en", i, 16'(wr_en), 16'd0);
    end
    step(0, 1, 8'h77, 0, 0);
    chk("resync_wr_addr", 0, 16'(wr_addr), 16'd8);
    chk("resync_wr_data", 0, 16'(wr_data), 16'h77);

    // read scan over bank 0 with wrap
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 8'h00, 1, 0);
      chk("scan_rd_addr", i, 16'(rd_addr), 16'((i + 1) % 8));
    end
    // frame_end in FILL at rcnt=5 with rd_en: restart, no swap
    step(0, 0, 8'h00, 1, 1);
    chk("fe_fill_rd_addr", 0, 16'(rd_addr), 16'd0);
    chk("fe_fill_img_valid", 0, 16'(img_valid), 16'd1);
    step(0, 1, 8'h78, 0, 0);
    chk("fe_fill_wr_addr", 0, 16'(wr_addr), 16'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
